fir_mac_cell: RTL and testbench

FIR_MAC_CELL -- requirements
Module: fir_mac_cell

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_round.sv | 69 ++++++
 rtl/fir_mac_cell.sv | 194 +++++++++++++++++++
 tb/tb_fir_mac_cell.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR MAC cell.
//   rnd_mode_e : per-sample rounding mode encoding (value 3 is treated as truncate)
//   PIPE_LAT   : cycles from an accepted sample to its partial sum at c_out
package fir_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC   = 2'd0,
        RND_HALF_UP = 2'd1,
        RND_CONV    = 2'd2
    } rnd_mode_e;

    localparam int PIPE_LAT = 4;

endpackage

// File: rtl/fir_round.sv
// fir_round: registered rounding stage. Drops FRAC_BITS LSBs from a signed
// IN_W-bit product and produces an OUT_W = IN_W-FRAC_BITS+1 bit result; the
// extra bit absorbs the carry when rounding up the most positive value.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   mode_in      : rounding mode (rnd_mode_e encoding, 3 behaves as truncate)
//   data_in      : signed product to round
//   data_out     : signed rounded value, one cycle later
module fir_round
    import fir_pkg::*;
#(
    parameter  int IN_W      = 28,
    parameter  int FRAC_BITS = 16,
    localparam int OUT_W     = IN_W - FRAC_BITS + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              mode_in,
    input  logic signed [IN_W-1:0]  data_in,
    output logic signed [OUT_W-1:0] data_out
);

    localparam int EXT_W = IN_W + 1;

    function automatic logic signed [OUT_W-1:0] round_val(
        input logic signed [IN_W-1:0] x,
        input logic [1:0]             mode
    );
        logic signed [EXT_W-1:0]  xe;
        logic signed [EXT_W-1:0]  fl;
        logic signed [EXT_W-1:0]  half_v;
        logic [FRAC_BITS-1:0]     frac;
        logic [FRAC_BITS-1:0]     half_f;
        xe     = EXT_W'(x);
        half_v = EXT_W'(1) <<< (FRAC_BITS - 1);
        half_f = FRAC_BITS'(1) << (FRAC_BITS - 1);
        frac   = x[FRAC_BITS-1:0];
        fl     = xe >>> FRAC_BITS;
        case (mode)
            RND_HALF_UP: fl = (xe + half_v) >>> FRAC_BITS;
            // Exact halves go to the even neighbour; above-half always rounds up.
            RND_CONV: begin
                if ((frac > half_f) || ((frac == half_f) && fl[0])) begin
                    fl = fl + EXT_W'(1);
                end
            end
            default: ;
        endcase
        return fl[OUT_W-1:0];
    endfunction

    logic signed [OUT_W-1:0] data_d;
    logic signed [OUT_W-1:0] data_q;

    always_comb begin
        data_d = round_val(data_in, mode_in);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/fir_mac_cell.sv
// fir_mac_cell: one systolic FIR tap. Multiplies the sample by a double-
// buffered coefficient, rounds the product, and adds the upstream partial sum.
// Pipeline: S1 capture, S2 multiply, S3 round (fir_round), S4 add -> c_out.
// Optional feature macro MAC_SAT_EN: saturate the S4 sum and report a sticky
// sat_flag; when undefined the sum wraps and sat_flag is tied low.
// Ports:
//   clock, reset              : rising-edge clock, synchronous active-high reset
//   in_valid                  : qualifies b_in, c_in, rnd_mode
//   b_in, c_in, rnd_mode      : sample, upstream partial sum, rounding mode
//   coeff_wr, coeff_wdata     : load shadow coefficient
//   coeff_commit              : copy shadow into active coefficient
//   b_out, b_valid_out        : sample forwarded to the next tap (1 cycle)
//   c_out, c_valid_out        : partial sum out (4 cycles)
//   sat_flag, sat_clr         : sticky overflow flag and its clear
module fir_mac_cell
    import fir_pkg::*;
#(
    parameter int B_WIDTH   = 12,
    parameter int C_WIDTH   = 12,
    parameter int COEFF_W   = 16,
    parameter int FRAC_BITS = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic signed [B_WIDTH-1:0] b_in,
    input  logic signed [C_WIDTH-1:0] c_in,
    input  logic [1:0]                rnd_mode,
    input  logic                      coeff_wr,
    input  logic signed [COEFF_W-1:0] coeff_wdata,
    input  logic                      coeff_commit,
    output logic signed [B_WIDTH-1:0] b_out,
    output logic                      b_valid_out,
    output logic signed [C_WIDTH-1:0] c_out,
    output logic                      c_valid_out,
    output logic                      sat_flag,
    input  logic                      sat_clr
);

    localparam int PROD_W = COEFF_W + B_WIDTH;
    localparam int RND_W  = PROD_W - FRAC_BITS + 1;
    localparam int SUM_W  = C_WIDTH + 1;
    localparam int MAX_W  = (RND_W > SUM_W) ? RND_W : SUM_W;

    // The sum fits C_WIDTH bits exactly when its two top bits agree.
    function automatic logic sum_ovf(input logic signed [SUM_W-1:0] s);
        return s[SUM_W-1] != s[SUM_W-2];
    endfunction

    function automatic logic signed [C_WIDTH-1:0] sum_clamp(input logic signed [SUM_W-1:0] s);
        if (!sum_ovf(s)) begin
            return s[C_WIDTH-1:0];
        end else if (s[SUM_W-1]) begin
            return {1'b1, {(C_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(C_WIDTH-1){1'b1}}};
        end
    endfunction

    logic signed [COEFF_W-1:0] shadow_d, shadow_q;
    logic signed [COEFF_W-1:0] active_d, active_q;
    logic                      vld_p1_d, vld_p1_q;
    logic signed [B_WIDTH-1:0] b_p1_d, b_p1_q;
    logic signed [C_WIDTH-1:0] c_p1_d, c_p1_q;
    logic [1:0]                rnd_p1_d, rnd_p1_q;
    logic signed [COEFF_W-1:0] coef_p1_d, coef_p1_q;
    logic                      vld_p2_d, vld_p2_q;
    logic signed [PROD_W-1:0]  prod_p2_d, prod_p2_q;
    logic signed [C_WIDTH-1:0] c_p2_d, c_p2_q;
    logic [1:0]                rnd_p2_d, rnd_p2_q;
    logic                      vld_p3_d, vld_p3_q;
    logic signed [C_WIDTH-1:0] c_p3_d, c_p3_q;
    logic signed [RND_W-1:0]   rnd_p3;
    logic signed [MAX_W-1:0]   rnd_wide_p3;
    logic signed [SUM_W-1:0]   sum_p3;
    logic                      vld_p4_d, vld_p4_q;
    logic signed [C_WIDTH-1:0] c_p4_d, c_p4_q;

    always_comb begin
        shadow_d = coeff_wr ? coeff_wdata : shadow_q;
        // Using shadow_d makes a same-cycle write+commit activate the new data.
        active_d = coeff_commit ? shadow_d : active_q;

        // S1 capture: coefficient is latched with the sample so later commits
        // do not disturb samples already in flight.
        vld_p1_d  = in_valid;
        b_p1_d    = b_in;
        c_p1_d    = c_in;
        rnd_p1_d  = rnd_mode;
        coef_p1_d = active_q;

        // S2 multiply at full width
        vld_p2_d  = vld_p1_q;
        prod_p2_d = PROD_W'(b_p1_q) * PROD_W'(coef_p1_q);
        c_p2_d    = c_p1_q;
        rnd_p2_d  = rnd_p1_q;

        // S3 round happens inside fir_round; c_in rides alongside
        vld_p3_d  = vld_p2_q;
        c_p3_d    = c_p2_q;

        // S4 add at C_WIDTH+1 bits
        rnd_wide_p3 = MAX_W'(rnd_p3);
        sum_p3      = SUM_W'(c_p3_q) + $signed(rnd_wide_p3[SUM_W-1:0]);
        vld_p4_d    = vld_p3_q;
`ifdef MAC_SAT_EN
        c_p4_d      = sum_clamp(sum_p3);
`else
        c_p4_d      = sum_p3[C_WIDTH-1:0];
`endif
    end

    fir_round #(
        .IN_W      (PROD_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round (
        .clock    (clock),
        .reset    (reset),
        .mode_in  (rnd_p2_q),
        .data_in  (prod_p2_q),
        .data_out (rnd_p3)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            vld_p1_q  <= 1'b0;
            b_p1_q    <= '0;
            c_p1_q    <= '0;
            rnd_p1_q  <= '0;
            coef_p1_q <= '0;
            vld_p2_q  <= 1'b0;
            prod_p2_q <= '0;
            c_p2_q    <= '0;
            rnd_p2_q  <= '0;
            vld_p3_q  <= 1'b0;
            c_p3_q    <= '0;
            vld_p4_q  <= 1'b0;
            c_p4_q    <= '0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            vld_p1_q  <= vld_p1_d;
            b_p1_q    <= b_p1_d;
            c_p1_q    <= c_p1_d;
            rnd_p1_q  <= rnd_p1_d;
            coef_p1_q <= coef_p1_d;
            vld_p2_q  <= vld_p2_d;
            prod_p2_q <= prod_p2_d;
            c_p2_q    <= c_p2_d;
            rnd_p2_q  <= rnd_p2_d;
            vld_p3_q  <= vld_p3_d;
            c_p3_q    <= c_p3_d;
            vld_p4_q  <= vld_p4_d;
            c_p4_q    <= c_p4_d;
        end
    end

`ifdef MAC_SAT_EN
    logic sat_d, sat_q;

    // A new overflow wins over a simultaneous clear.
    always_comb begin
        sat_d = sat_q;
        if (sat_clr) begin
            sat_d = 1'b0;
        end
        if (vld_p3_q && sum_ovf(sum_p3)) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    logic unused_sat;
    assign unused_sat = ^{sat_clr, sum_p3[SUM_W-1], sum_clamp(sum_p3)};
    assign sat_flag   = 1'b0;
`endif

    assign b_out       = b_p1_q;
    assign b_valid_out = vld_p1_q;
    assign c_out       = c_p4_q;
    assign c_valid_out = vld_p4_q;

endmodule

// File: tb/tb_fir_mac_cell.sv
// Bench for fir_mac_cell at default parameters. A driver pushes expected
// outputs (value and due cycle) into queues; a monitor on the falling edge
// checks every cycle's valids and pops/compares data when due.
module tb_fir_mac_cell;
    import fir_pkg::*;

    localparam int BW = 12;
    localparam int CW = 12;
    localparam int KW = 16;
`ifdef MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic signed [BW-1:0] b_in = '0;
    logic signed [CW-1:0] c_in = '0;
    logic [1:0]           rnd_mode = '0;
    logic                 coeff_wr = 1'b0;
    logic signed [KW-1:0] coeff_wdata = '0;
    logic                 coeff_commit = 1'b0;
    logic signed [BW-1:0] b_out;
    logic                 b_valid_out;
    logic signed [CW-1:0] c_out;
    logic                 c_valid_out;
    logic                 sat_flag;
    logic                 sat_clr = 1'b0;

    fir_mac_cell dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .b_in         (b_in),
        .c_in         (c_in),
        .rnd_mode     (rnd_mode),
        .coeff_wr     (coeff_wr),
        .coeff_wdata  (coeff_wdata),
        .coeff_commit (coeff_commit),
        .b_out        (b_out),
        .b_valid_out  (b_valid_out),
        .c_out        (c_out),
        .c_valid_out  (c_valid_out),
        .sat_flag     (sat_flag),
        .sat_clr      (sat_clr)
    );

    always #5 clock = ~clock;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t cq[$];
    exp_t bq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int expv);
        checks = checks + 1;
        if (got != expv) begin
            errors = errors + 1;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, expv);
        end
    endtask

    // Monitor
    logic ev_c, ev_b;
    exp_t e_c, e_b;
    always @(negedge clock) begin
        ev_c = (cq.size() > 0) && (cq[0].due == cyc);
        check("c_valid_out", int'(c_valid_out), int'(ev_c));
        if (ev_c) begin
            e_c = cq.pop_front();
            check("c_out", int'(c_out), e_c.val);
        end
        ev_b = (bq.size() > 0) && (bq[0].due == cyc);
        check("b_valid_out", int'(b_valid_out), int'(ev_b));
        if (ev_b) begin
            e_b = bq.pop_front();
            check("b_out", int'(b_out), e_b.val);
        end
    end

    task automatic drive(input logic v, input int b, input int c, input int mode,
                         input logic wr, input int wd, input logic cm, input logic clr,
                         input logic push, input int expv);
        @(negedge clock);
        in_valid     = v;
        b_in         = b[BW-1:0];
        c_in         = c[CW-1:0];
        rnd_mode     = mode[1:0];
        coeff_wr     = wr;
        coeff_wdata  = wd[KW-1:0];
        coeff_commit = cm;
        sat_clr      = clr;
        if (v) begin
            bq.push_back('{b, cyc + 1});
            if (push) cq.push_back('{expv, cyc + PIPE_LAT});
        end
    endtask

    task automatic send(input int b, input int c, input int mode, input int expv);
        drive(1'b1, b, c, mode, 1'b0, 0, 1'b0, 1'b0, 1'b1, expv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_b_out"}, int'(b_out), 0);
        check({tag, "_c_out"}, int'(c_out), 0);
        check({tag, "_b_valid"}, int'(b_valid_out), 0);
        check({tag, "_c_valid"}, int'(c_valid_out), 0);
        check({tag, "_sat_flag"}, int'(sat_flag), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clock);
        check_zero_outputs("reset");
        reset = 1'b0;

        // Active coefficient is zero out of reset: sum is c_in alone
        send(400, 7, 0, 7);
        idle(1);

        // Load 0x4000 into shadow, then commit separately
        drive(1'b0, 0, 0, 0, 1'b1, 'h4000, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);

        // 0.25 * sample, with and without upstream sum
        send(400, 0, 0, 100);
        send(-400, 0, 0, -100);
        send(400, -300, 0, -200);
        idle(1);

        // Positive overflow, then clear
        send(400, 2047, 0, SAT ? 2047 : -1949);
        idle(5);
        check("sat_flag_pos", int'(sat_flag), int'(SAT));
        drive(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
        idle(1);
        check("sat_flag_clr", int'(sat_flag), 0);

        // Negative overflow with sat_clr asserted at the very edge it lands
        send(-400, -2048, 0, SAT ? -2048 : 1948);
        idle(2);
        drive(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
        idle(1);
        check("sat_flag_clr_vs_ovf", int'(sat_flag), int'(SAT));
        drive(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
        idle(1);
        check("sat_flag_clr2", int'(sat_flag), 0);

        // Rounding with coefficient 0.125 (write+commit same cycle)
        drive(1'b0, 0, 0, 0, 1'b1, 'h2000, 1'b1, 1'b0, 1'b0, 0);
        send(12, 0, 0, 1);
        send(12, 0, 1, 2);
        send(12, 0, 2, 2);
        send(12, 0, 3, 1);
        send(4, 0, 0, 0);
        send(4, 0, 1, 1);
        send(4, 0, 2, 0);
        send(-12, 0, 0, -2);
        send(-12, 0, 1, -1);
        send(-12, 0, 2, -2);
        send(-4, 0, 0, -1);
        send(-4, 0, 1, 0);
        send(-4, 0, 2, 0);
        send(20, 0, 1, 3);
        send(20, 0, 2, 2);
        send(12, -10, 1, -8);
        idle(1);

        // Double-buffered coefficient mid-stream
        drive(1'b0, 0, 0, 0, 1'b1, 'h4000, 1'b1, 1'b0, 1'b0, 0);
        send(400, 0, 0, 100);
        drive(1'b1, 400, 0, 0, 1'b1, 'h2000, 1'b0, 1'b0, 1'b1, 100);
        send(400, 0, 0, 100);
        drive(1'b1, 400, 0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 100);
        send(400, 0, 0, 50);
        send(400, 0, 0, 50);
        drive(1'b1, 400, 0, 0, 1'b1, 'h4000, 1'b1, 1'b0, 1'b1, 50);
        send(400, 0, 0, 100);
        idle(1);

        // Bubbles: alternating valid pattern
        for (int i = 0; i < 6; i++) begin
            send(400, i, 0, 100 + i);
            idle(1);
        end
        idle(5);

        // Reset with three samples in flight: none of them may emerge
        drive(1'b1, 400, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b1, 400, 1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b1, 400, 2, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        check_zero_outputs("midreset");
        reset = 1'b0;
        idle(6);

        // Coefficient was cleared by reset
        send(400, 5, 0, 5);
        idle(8);

        check("drain_c", cq.size(), 0);
        check("drain_b", bq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
